// File: rtl/combo_lock_param.sv
// -----------------------------------------------------------------------------
// combo_lock_param
//
// Parametrised sequence lock. It sits between the keypad symbol encoder
// (symbol 0 means no entry) and the latch driver / alarm logic.
//
// The lock accepts a code of LEN symbols, each SYM_W bits wide. A wrong
// full-length entry pulses err and bumps a consecutive-failure counter.
// MAX_FAIL consecutive failures raise the alarm for LOCKOUT_CYC cycles.
// A correct entry releases the latch for OPEN_CYC cycles. During that
// window the code can be re-programmed.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-low reset
//   sym          in   keypad symbol; any non-zero value is one entry per cycle
//   prog         in   request to program a new code (honoured only while open)
//   unlocked     out  latch release, high for OPEN_CYC cycles
//   alarm        out  high for the whole lockout
//   programming  out  high while a new code is being keyed in
//   err          out  one-cycle pulse after a wrong full-length entry
//   prog_done    out  one-cycle pulse when a new code is committed
//   fail_cnt     out  consecutive failed attempts, saturating at MAX_FAIL
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module combo_lock_param #(
    parameter int                    SYM_W        = 2,
    parameter int                    LEN          = 5,
    parameter logic [LEN*SYM_W-1:0]  DEFAULT_CODE = {2'd1, 2'd2, 2'd3, 2'd2, 2'd1},
    parameter int                    OPEN_CYC     = 8,
    parameter int                    MAX_FAIL     = 3,
    parameter int                    LOCKOUT_CYC  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [SYM_W-1:0]                sym,
    input  logic                            prog,
    output logic                            unlocked,
    output logic                            alarm,
    output logic                            programming,
    output logic                            err,
    output logic                            prog_done,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

    localparam int IDX_W   = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int TMR_MAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int FC_W    = $clog2(MAX_FAIL + 1);
    localparam int CODE_W  = LEN * SYM_W;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);
    localparam logic [TMR_W-1:0] TMR_OPEN = TMR_W'(OPEN_CYC);
    localparam logic [TMR_W-1:0] TMR_LOCK = TMR_W'(LOCKOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAIL);

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_OPEN,
        ST_PROG,
        ST_LOCKOUT
    } state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic                mismatch, mismatch_nxt;
    logic [TMR_W-1:0]    timer, timer_nxt;
    logic [CODE_W-1:0]   code, code_nxt;
    logic [CODE_W-1:0]   shadow, shadow_nxt;
    logic                unlocked_nxt, alarm_nxt, programming_nxt;
    logic                err_nxt, prog_done_nxt;
    logic [FC_W-1:0]     fail_nxt, fail_inc;
    logic                mism_now;
    int                  fld;

    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        mismatch_nxt    = mismatch;
        timer_nxt       = timer;
        code_nxt        = code;
        shadow_nxt      = shadow;
        unlocked_nxt    = unlocked;
        alarm_nxt       = alarm;
        programming_nxt = programming;
        err_nxt         = 1'b0;
        prog_done_nxt   = 1'b0;
        fail_nxt        = fail_cnt;

        // The first symbol lives in the MSB field, so position idx maps to
        // field LEN-1-idx counted from the LSB.
        fld      = (LEN - 1 - int'(idx)) * SYM_W;
        mism_now = mismatch | (sym != code[fld +: SYM_W]);
        fail_inc = (fail_cnt == FC_MAX) ? FC_MAX : fail_cnt + FC_W'(1);

        case (state)
            ST_ENTRY: begin
                if (sym != '0) begin
                    if (idx == IDX_LAST) begin
                        // Verdict only after exactly LEN entries; no early reject.
                        idx_nxt      = '0;
                        mismatch_nxt = 1'b0;
                        if (!mism_now) begin
                            state_nxt    = ST_OPEN;
                            unlocked_nxt = 1'b1;
                            timer_nxt    = TMR_OPEN;
                            fail_nxt     = '0;
                        end else begin
                            err_nxt  = 1'b1;
                            fail_nxt = fail_inc;
                            if (fail_inc == FC_MAX) begin
                                state_nxt = ST_LOCKOUT;
                                alarm_nxt = 1'b1;
                                timer_nxt = TMR_LOCK;
                            end
                        end
                    end else begin
                        idx_nxt      = idx + IDX_W'(1);
                        mismatch_nxt = mism_now;
                    end
                end
            end

            ST_OPEN: begin
                // prog wins over timer expiry on the same edge.
                if (prog) begin
                    state_nxt       = ST_PROG;
                    unlocked_nxt    = 1'b0;
                    programming_nxt = 1'b1;
                    idx_nxt         = '0;
                end else if (timer == TMR_ONE) begin
                    state_nxt    = ST_ENTRY;
                    unlocked_nxt = 1'b0;
                    idx_nxt      = '0;
                    mismatch_nxt = 1'b0;
                end else begin
                    timer_nxt = timer - TMR_ONE;
                end
            end

            ST_PROG: begin
                if (sym != '0) begin
                    shadow_nxt[fld +: SYM_W] = sym;
                    if (idx == IDX_LAST) begin
                        // Commit the whole code at once, including this symbol.
                        code_nxt        = shadow_nxt;
                        idx_nxt         = '0;
                        mismatch_nxt    = 1'b0;
                        programming_nxt = 1'b0;
                        prog_done_nxt   = 1'b1;
                        state_nxt       = ST_ENTRY;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end

            ST_LOCKOUT: begin
                if (timer == TMR_ONE) begin
                    state_nxt = ST_ENTRY;
                    alarm_nxt = 1'b0;
                    fail_nxt  = '0;
                end else begin
                    timer_nxt = timer - TMR_ONE;
                end
            end

            default: begin
                state_nxt = ST_ENTRY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_ENTRY;
            idx         <= '0;
            mismatch    <= 1'b0;
            timer       <= '0;
            code        <= DEFAULT_CODE;
            unlocked    <= 1'b0;
            alarm       <= 1'b0;
            programming <= 1'b0;
            err         <= 1'b0;
            prog_done   <= 1'b0;
            fail_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            mismatch    <= mismatch_nxt;
            timer       <= timer_nxt;
            code        <= code_nxt;
            unlocked    <= unlocked_nxt;
            alarm       <= alarm_nxt;
            programming <= programming_nxt;
            err         <= err_nxt;
            prog_done   <= prog_done_nxt;
            fail_cnt    <= fail_nxt;
        end
    end

    // Shadow contents only matter once every field has been rewritten in PROG.
    always_ff @(posedge clk) begin
        shadow <= shadow_nxt;
    end

endmodule

// File: tb/tb_combo_lock_param.sv
module tb_combo_lock_param;

    localparam int LEN         = 5;
    localparam int OPEN_CYC    = 8;
    localparam int MAX_FAIL    = 3;
    localparam int LOCKOUT_CYC = 16;

    logic       clk;
    logic       reset;
    logic [1:0] sym;
    logic       prog;
    logic       unlocked, alarm, programming, err, prog_done;
    logic [1:0] fail_cnt;

    combo_lock_param dut (
        .clk        (clk),
        .reset      (reset),
        .sym        (sym),
        .prog       (prog),
        .unlocked   (unlocked),
        .alarm      (alarm),
        .programming(programming),
        .err        (err),
        .prog_done  (prog_done),
        .fail_cnt   (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: symbols queued, compared as a whole code
    int def_code[LEN] = '{1, 2, 3, 2, 1};
    int m_code[LEN];
    int m_q[$];
    int m_open = 0;     // unlocked cycles remaining
    int m_lock = 0;     // alarm cycles remaining
    bit m_prog = 0;
    int m_fail = 0;
    bit m_err  = 0;
    bit m_done = 0;

    function automatic void model_step(int s, bit p, bit r);
        bit ok;
        m_err  = 0;
        m_done = 0;
        if (!r) begin
            m_open = 0; m_lock = 0; m_prog = 0; m_fail = 0;
            m_q.delete();
            foreach (m_code[i]) m_code[i] = def_code[i];
            return;
        end
        if (m_open > 0) begin
            if (p) begin
                m_open = 0;
                m_prog = 1;
                m_q.delete();
            end else begin
                m_open--;
            end
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_fail = 0;
        end else if (m_prog) begin
            if (s != 0) m_q.push_back(s);
            if (m_q.size() == LEN) begin
                foreach (m_code[i]) m_code[i] = m_q[i];
                m_q.delete();
                m_prog = 0;
                m_done = 1;
            end
        end else begin
            if (s != 0) m_q.push_back(s);
            if (m_q.size() == LEN) begin
                ok = 1;
                foreach (m_code[i]) if (m_q[i] != m_code[i]) ok = 0;
                if (ok) begin
                    m_open = OPEN_CYC;
                    m_fail = 0;
                end else begin
                    m_err = 1;
                    m_fail++;
                    if (m_fail >= MAX_FAIL) begin
                        m_fail = MAX_FAIL;
                        m_lock = LOCKOUT_CYC;
                    end
                end
                m_q.delete();
            end
        end
    endfunction

    task automatic step(input int s, input bit p, input bit r);
        @(negedge clk);
        sym   = 2'(s);
        prog  = p;
        reset = r;
        @(posedge clk);
        model_step(s, p, r);
        #1;
    endtask

    task automatic check_model();
        chk("unlocked",    unlocked,    32'(m_open > 0));
        chk("alarm",       alarm,       32'(m_lock > 0));
        chk("programming", programming, 32'(m_prog));
        chk("err",         err,         32'(m_err));
        chk("prog_done",   prog_done,   32'(m_done));
        chk("fail_cnt",    fail_cnt,    32'(m_fail));
        chk("exclusive",   32'(int'(unlocked) + int'(alarm) + int'(programming) <= 1), 1);
    endtask

    task automatic go(input int s, input bit p, input bit r);
        step(s, p, r);
        check_model();
    endtask

    task automatic enter5(input int a, input int b, input int c, input int d, input int e);
        go(a, 0, 1); go(b, 0, 1); go(c, 0, 1); go(d, 0, 1); go(e, 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) go(0, 0, 1);
    endtask

    // ---------------- directed vector table
    typedef struct {
        int sym; bit prog; bit rst_n;
        bit u; bit a; bit p; bit e; bit d; int f;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(int s, bit pr, bit r, bit u, bit a, bit p, bit e, bit d, int f);
        vec_t v;
        v.sym = s; v.prog = pr; v.rst_n = r;
        v.u = u; v.a = a; v.p = p; v.e = e; v.d = d; v.f = f;
        vecs.push_back(v);
    endfunction

    initial begin
        int n_err, n_alarm, n_unl;
        int s;
        bit p, r;

        reset = 1'b0;
        sym   = '0;
        prog  = 1'b0;

        // Plan 1: reset, default code with gaps, 8 open cycles.
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0); add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(2, 0, 1, 0, 0, 0, 0, 0, 0); add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(3, 0, 1, 0, 0, 0, 0, 0, 0); add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(2, 0, 1, 0, 0, 0, 0, 0, 0); add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Plan 2: one wrong code, then the right one clears fail_cnt.
        add(1, 0, 1, 0, 0, 0, 0, 0, 0); add(2, 0, 1, 0, 0, 0, 0, 0, 0);
        add(3, 0, 1, 0, 0, 0, 0, 0, 0); add(2, 0, 1, 0, 0, 0, 0, 0, 0);
        add(2, 0, 1, 0, 0, 0, 1, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 0, 1, 0, 0, 0, 0, 0, 1); add(2, 0, 1, 0, 0, 0, 0, 0, 1);
        add(3, 0, 1, 0, 0, 0, 0, 0, 1); add(2, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 0, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].sym, vecs[i].prog, vecs[i].rst_n);
            chk($sformatf("vec%0d_unlocked", i), unlocked, 32'(vecs[i].u));
            chk($sformatf("vec%0d_alarm", i), alarm, 32'(vecs[i].a));
            chk($sformatf("vec%0d_programming", i), programming, 32'(vecs[i].p));
            chk($sformatf("vec%0d_err", i), err, 32'(vecs[i].e));
            chk($sformatf("vec%0d_prog_done", i), prog_done, 32'(vecs[i].d));
            chk($sformatf("vec%0d_fail_cnt", i), fail_cnt, 32'(vecs[i].f));
            check_model();
        end

        // Plan 3: three wrong codes -> 16-cycle alarm, correct code ignored.
        n_err = 0;
        for (int k = 0; k < 3; k++) begin
            go(2, 0, 1); if (err) n_err++;
            go(2, 0, 1); if (err) n_err++;
            go(2, 0, 1); if (err) n_err++;
            go(2, 0, 1); if (err) n_err++;
            go(2, 0, 1); if (err) n_err++;
        end
        chk("t3_err_pulses", n_err, 3);
        chk("t3_alarm_on", alarm, 1);
        n_alarm = int'(alarm);
        n_unl = 0;
        for (int i = 0; i < 20; i++) begin
            go((i < 15) ? def_code[i % LEN] : 0, 0, 1);
            if (alarm) n_alarm++;
            if (unlocked) n_unl++;
        end
        chk("t3_alarm_cycles", n_alarm, 16);
        chk("t3_no_unlock_in_alarm", n_unl, 0);
        chk("t3_fail_cleared", fail_cnt, 0);
        enter5(1, 2, 3, 2, 1);
        chk("t3_unlock_after", unlocked, 1);
        idle(10);

        // Plan 4: program 3,3,1,1,2 from the 3rd open cycle.
        enter5(1, 2, 3, 2, 1);
        idle(1);
        go(0, 1, 1);
        chk("t4_programming", programming, 1);
        chk("t4_unlocked_drop", unlocked, 0);
        enter5(3, 3, 1, 1, 2);
        chk("t4_prog_done", prog_done, 1);
        idle(1);
        chk("t4_prog_done_pulse", prog_done, 0);
        enter5(1, 2, 3, 2, 1);
        chk("t4_old_code_err", err, 1);
        enter5(3, 3, 1, 1, 2);
        chk("t4_new_code_unlocks", unlocked, 1);
        idle(10);

        // Plan 5: reset in the middle of programming restores the default.
        enter5(3, 3, 1, 1, 2);
        go(0, 1, 1);
        go(1, 0, 1); go(1, 0, 1);
        go(0, 0, 0);
        chk("t5_prog_cleared", programming, 0);
        chk("t5_unlocked_cleared", unlocked, 0);
        enter5(1, 2, 3, 2, 1);
        chk("t5_default_unlocks", unlocked, 1);
        idle(10);

        // Plan 6: reset mid-entry and mid-open.
        go(1, 0, 1); go(2, 0, 1); go(3, 0, 1);
        go(0, 0, 0);
        go(2, 0, 1); go(1, 0, 1);
        chk("t6_partial_no_unlock", unlocked, 0);
        go(0, 0, 0);
        enter5(1, 2, 3, 2, 1);
        idle(2);
        go(0, 0, 0);
        chk("t6_open_reset", unlocked, 0);
        go(1, 0, 1); go(2, 0, 1); go(3, 0, 1); go(2, 0, 1);
        chk("t6_four_not_enough", unlocked, 0);
        go(1, 0, 1);
        chk("t6_full_unlocks", unlocked, 1);
        idle(10);

        // Randomised traffic, biased toward the expected next symbol.
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 249) != 0);
            p = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) < 7 && m_q.size() < LEN)
                s = m_code[m_q.size()];
            else
                s = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) s = 0;
            go(s, p, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/combo_lock_param.md
Name: combo_lock_param

Overview:
- Parametrised successor to the 2-bit-symbol sequence lock (default code A B C B A).
- Symbol width, code length, open time and failure policy are generics.
- Adds: failed-attempt counting with timed lockout/alarm, and runtime re-programming of the code while unlocked.
- Sits between the keypad symbol encoder (symbol 0 = no entry) and the latch driver / alarm logic.

Parameters:
- SYM_W, 2: symbol width in bits. Value 0 means "no entry"; values 1..2^SYM_W-1 are valid symbols (default: 1=A, 2=B, 3=C).
- LEN, 5: number of symbols in the code.
- DEFAULT_CODE, {2'd1,2'd2,2'd3,2'd2,2'd1}: LEN*SYM_W bits, code after reset. The MSB field is the first symbol. Every field must be non-zero.
- OPEN_CYC, 8: cycles that `unlocked` stays high.
- MAX_FAIL, 3: consecutive wrong codes that trigger lockout.
- LOCKOUT_CYC, 16: cycles that lockout lasts.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-low reset.
- sym, in, SYM_W: keypad symbol, sampled every rising edge; a non-zero value counts as one entry per cycle.
- prog, in, 1: request to program a new code; honoured only in OPEN.
- unlocked, out, 1: latch release.
- alarm, out, 1: high throughout LOCKOUT.
- programming, out, 1: high throughout PROG.
- err, out, 1: one-cycle pulse after a wrong full-length entry.
- prog_done, out, 1: one-cycle pulse when a new code is committed.
- fail_cnt, out, $clog2(MAX_FAIL+1): consecutive failures so far.

Behaviour:
- Reset (reset==0 at an edge):
  - state=ENTRY, idx=0, mismatch=0.
  - All outputs 0, fail_cnt=0, code=DEFAULT_CODE.
  - Reset overrides every other event.
  - Reset during PROG discards any partial code; DEFAULT_CODE is restored.
- All outputs are registered. A symbol sampled at edge k affects the outputs from edge k onward (visible in cycle k+1).
- ENTRY:
  - sym==0: hold.
  - sym!=0: compare with code[idx] and set mismatch |= (sym!=code[idx]).
  - No early reject: the verdict is given only after exactly LEN entries.
  - If idx<LEN-1: idx++.
  - If idx==LEN-1 and no mismatch: go to OPEN, unlocked=1, fail_cnt=0.
  - If idx==LEN-1 with a mismatch:
    - err pulses for 1 cycle and fail_cnt++.
    - If the new fail_cnt==MAX_FAIL: go to LOCKOUT, alarm=1.
    - Otherwise stay in ENTRY.
  - On either verdict, idx=0 and mismatch=0.
- OPEN:
  - unlocked=1 for exactly OPEN_CYC cycles.
  - sym is ignored.
  - prog==1 at any edge in OPEN: unlocked=0 and go to PROG (prog takes priority over timer expiry on the same edge).
  - On timer expiry: go to ENTRY.
- PROG:
  - programming=1.
  - Each sym!=0 writes the shadow register shadow[idx], then idx++.
  - At the LEN-th symbol: shadow is copied into code (the code register is updated atomically), prog_done pulses, and the block goes to ENTRY.
  - sym==0 holds; prog is ignored; there is no timeout.
- LOCKOUT:
  - alarm=1 for exactly LOCKOUT_CYC cycles; sym and prog are ignored.
  - On exit: alarm=0, fail_cnt=0, go to ENTRY.
- Counters:
  - idx: $clog2(LEN) bits.
  - Timers: $clog2(max(OPEN_CYC,LOCKOUT_CYC)+1) bits, loaded on state entry and counted down to 1.
  - fail_cnt saturates at MAX_FAIL.
- Consecutive identical symbols on back-to-back cycles are separate entries. Idle cycles between symbols are allowed and unlimited.
- Invariant: unlocked, alarm and programming are mutually exclusive.

Test Plan:
1. Defaults, sym sequence 1,2,3,2,1 (one per cycle, with 0 gaps) -> unlocked=1 on the edge after the last 1, held 8 cycles then 0; fail_cnt=0; err never pulses.
2. Enter 1,2,3,2,2 -> err pulses once after the 5th entry, fail_cnt=1, unlocked stays 0. Then enter 1,2,3,2,1 -> unlock, fail_cnt=0.
3. Three wrong 5-symbol codes -> err pulses 3 times, alarm=1 for exactly 16 cycles. The correct code entered during alarm is ignored. After the lockout ends, fail_cnt=0 and the correct code unlocks.
4. Unlock, assert prog at the 3rd open cycle, enter 3,3,1,1,2 -> programming=1, prog_done pulses after the 5th symbol. Old code 1,2,3,2,1 now gives err; 3,3,1,1,2 unlocks.
5. In PROG after 2 symbols, drive reset=0 for one edge -> all outputs 0, code=DEFAULT_CODE; 1,2,3,2,1 unlocks.
6. Reset asserted mid-entry (after 3 correct symbols) and mid-OPEN -> next cycle unlocked=0, idx=0; a full 5 symbols are required again.
